// File: rtl/rrp_otf_conv_if.sv
// Handshake bundle between the online adder (master) and the on-the-fly converter (slave).
interface rrp_otf_conv_if #(
    parameter int unsigned RADIX = 4,
    parameter int unsigned WIDTH = 6
);
    localparam int unsigned LR = $clog2(RADIX);
    localparam int unsigned D  = LR + 1;
    localparam int unsigned M  = WIDTH + 1;
    localparam int unsigned IW = M * D;
    localparam int unsigned OW = M * LR + 1;

    logic [IW-1:0] in_word;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_result;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_result, out_err, out_valid
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_result, out_err, out_valid
    );
endinterface

// File: rtl/rrp_otf_conv.sv
// MSD-first digit-serial on-the-fly converter: signed-digit word -> two's complement.
module rrp_otf_conv #(
    parameter int unsigned RADIX = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    rrp_otf_conv_if.slave bus
);
    localparam int unsigned LR = $clog2(RADIX);
    localparam int unsigned D  = LR + 1;
    localparam int unsigned M  = WIDTH + 1;
    localparam int unsigned IW = M * D;
    localparam int unsigned OW = M * LR + 1;
    localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
    localparam int          A  = int'(RADIX) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load;
    logic          w_step;

    logic [IW-1:0] r_word;
    logic [OW-1:0] r_q;
    logic [OW-1:0] r_qm;
    logic [KW-1:0] r_k;
    logic          r_err;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [D-1:0]  w_d;
    int            w_d_int;
    logic [OW-1:0] w_d_ext;
    logic [OW-1:0] w_q_mul;
    logic [OW-1:0] w_qm_mul;
    logic [OW-1:0] w_q_nxt;
    logic [OW-1:0] w_qm_nxt;
    logic          w_bad;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, M conversion steps, hold result until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_CONV;
            S_CONV:  if (r_k == '0)     w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE:  w_load = bus.in_valid;
            S_CONV:  w_step = 1'b1;
            default: begin
                w_load = 1'b0;
                w_step = 1'b0;
            end
        endcase
    end

    // One Q/QM recurrence step on the current most-significant captured digit
    always_comb begin
        w_d      = r_word[IW-1 -: D];
        w_d_int  = int'($signed(w_d));
        w_d_ext  = OW'($signed(w_d));
        w_q_mul  = r_q  * OW'(RADIX);
        w_qm_mul = r_qm * OW'(RADIX);
        w_bad    = (w_d_int > A) || (w_d_int < -A);
        if (!w_d[D-1]) begin
            w_q_nxt = w_q_mul + w_d_ext;
        end else begin
            w_q_nxt = w_qm_mul + OW'(RADIX) + w_d_ext;
        end
        if (!w_d[D-1] && (w_d != '0)) begin
            w_qm_nxt = w_q_mul + w_d_ext - OW'(1);
        end else begin
            w_qm_nxt = w_qm_mul + OW'(RADIX - 1) + w_d_ext;
        end
    end

    // Capture, digit shift, conversion registers, digit counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_q    <= '0;
            r_qm   <= '1;
            r_k    <= '0;
            r_err  <= 1'b0;
        end else if (w_load) begin
            r_word <= bus.in_word;
            r_q    <= '0;
            r_qm   <= '1;
            r_k    <= KW'(M - 1);
            r_err  <= 1'b0;
        end else if (w_step) begin
            r_word <= {r_word[IW-D-1:0], D'(0)};
            r_q    <= w_q_nxt;
            r_qm   <= w_qm_nxt;
            r_err  <= r_err | w_bad;
            if (r_k != '0) begin
                r_k <= r_k - KW'(1);
            end
        end
    end

    // Handshake flags registered from the next state so they track the FSM exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_q;
    assign bus.out_err    = r_err;
endmodule

// File: tb/tb_rrp_otf_conv.sv
// Directed self-checking bench for rrp_otf_conv (RADIX=4, WIDTH=6).
module tb_rrp_otf_conv;
    localparam int unsigned RADIX = 4;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned M     = WIDTH + 1;
    localparam int unsigned IW    = 21;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rrp_otf_conv_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus ();

    rrp_otf_conv #(.RADIX(RADIX), .WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pack digits d6..d0 (each 3-bit two's complement) into a word
    function automatic logic [IW-1:0] mkw(input int d6, input int d5, input int d4,
                                          input int d3, input int d2, input int d1,
                                          input int d0);
        logic [IW-1:0] w;
        w = '0;
        w[18 +: 3] = 3'(d6);
        w[15 +: 3] = 3'(d5);
        w[12 +: 3] = 3'(d4);
        w[9  +: 3] = 3'(d3);
        w[6  +: 3] = 3'(d2);
        w[3  +: 3] = 3'(d1);
        w[0  +: 3] = 3'(d0);
        return w;
    endfunction

    // Present a word for one cycle from IDLE; returns at the negedge after acceptance
    task automatic send(input string tag, input logic [IW-1:0] w);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count cycles to out_valid (bounded) and check latency, result and error flag
    task automatic expect_result(input string tag, input logic [31:0] exp_res,
                                 input logic [31:0] exp_err);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(M));
        chk({tag, "_result"}, 32'(bus.out_result), exp_res);
        chk({tag, "_err"}, 32'(bus.out_err), exp_err);
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Complete the output handshake and check the return to IDLE
    task automatic ack(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_word   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        #23;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send("zero", mkw(0, 0, 0, 0, 0, 0, 0));
        expect_result("zero", 32'h0000, 32'd0);
        ack("zero");

        send("msd", mkw(1, 0, 0, 0, 0, 0, 0));
        expect_result("msd", 32'h1000, 32'd0);
        ack("msd");

        send("qm_lsd", mkw(1, 0, 0, 0, 0, 0, -1));
        expect_result("qm_lsd", 32'h0FFF, 32'd0);
        ack("qm_lsd");

        send("all_m3", mkw(-3, -3, -3, -3, -3, -3, -3));
        expect_result("all_m3", 32'h4001, 32'd0);
        ack("all_m3");

        send("all_p3", mkw(3, 3, 3, 3, 3, 3, 3));
        expect_result("all_p3", 32'h3FFF, 32'd0);
        ack("all_p3");

        // Mixed digits: 2*1024 - 1*256 + 3*16 - 2*4 + 1 = 1833
        send("mixed", mkw(0, 2, -1, 0, 3, -2, 1));
        expect_result("mixed", 32'd1833, 32'd0);
        ack("mixed");

        // Back-pressure with a competing word held on the input
        send("bp", mkw(0, 0, 0, 0, 1, 2, 3));
        expect_result("bp", 32'd27, 32'd0);
        held         = 32'(bus.out_result);
        bus.in_word  = mkw(0, 0, 0, 0, 0, 1, 1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_result", 32'(bus.out_result), held);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp2_accepted", 32'(bus.in_ready), 32'd0);
        expect_result("bp2", 32'd5, 32'd0);
        ack("bp2");

        send("illegal", mkw(0, 0, 0, 0, 0, 0, -4));
        expect_result("illegal", 32'h7FFC, 32'd1);
        ack("illegal");

        send("legal_after", mkw(0, 0, 0, 0, 0, 2, 1));
        expect_result("legal_after", 32'd9, 32'd0);
        ack("legal_after");

        // Asynchronous reset while k=3 (three digits already folded in)
        send("abort", mkw(1, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("abort_pre_result", 32'(bus.out_result), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_result", 32'(bus.out_result), 32'd0);
        chk("abort_out_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send("post_rst", mkw(0, 0, 0, 0, 0, 0, 2));
        expect_result("post_rst", 32'd2, 32'd0);
        ack("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
